sine_pwm_multi: RTL and testbench
=================================

# sine_pwm_multi

Multi-channel PWM sine generator: a free-running PWM counter shared by CHANNELS outputs, each driven by its own phase accumulator, a half-wave-mirrored duty lookup, and amplitude scaling. It is the parametrised successor of the fixed 6-bit, 64-step single-channel PWM sine block. It adds programmable frequency, per-channel phase offset, amplitude control, and glitch-free duty updates at frame boundaries. Outputs feed pin drivers or external RC filters directly.

## Interface
- CHANNELS, 2: number of independent PWM outputs.
- PWM_W, 6: PWM counter and duty width. One frame is 2^PWM_W cycles.
- ACC_W, 12: phase accumulator width. Must be ≥ LUT_AW+1.
- LUT_AW, 5: half-wave ROM address width, giving 2^LUT_AW entries.
- LUT_FILE, "sine_half.hex": $readmemh image. Ascending raised-cosine half-wave, PWM_W-bit entries. The default image is 0,0,1,1,3,4,6,8,10,12,15,18,21,24,27,30,33,36,39,42,45,48,51,53,55,57,59,60,62,62,63,63.
- sysclk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  CHANNELS  per-channel enable.
- freq_step  in  ACC_W  phase increment per frame, shared by all channels.
- phase_off  in  CHANNELS*ACC_W  per-channel phase offset; channel c uses bits [c*ACC_W +: ACC_W].
- amp  in  PWM_W+1  amplitude. 2^PWM_W means unity; any larger value is clamped to unity.
- pulse  out  CHANNELS  registered PWM outputs.
- frame_tick  out  1  one-cycle pulse at the start of each frame.
- wrap  out  CHANNELS  one-cycle pulse when a channel's accumulator wraps.

## Operation
- cnt (PWM_W bits) increments every cycle and wraps modulo 2^PWM_W. frame_end = (cnt == 2^PWM_W−1).
- Per channel c:
  - p = acc[c] + phase_off[c], modulo 2^ACC_W.
  - h = p[ACC_W−1] selects the half; a = p[ACC_W−2 -: LUT_AW] is the address.
  - raw = h ? ROM[~a] : ROM[a]. The second half mirrors the first, so the peak entry repeats across the boundary.
  - scaled = (raw * min(amp, 2^PWM_W)) >> PWM_W, truncated. At unity, scaled equals raw exactly.
- The duty pipeline may be registered up to 2^PWM_W−2 cycles deep. It must be settled before frame_end.
- On each frame_end edge:
  - duty_act[c] <= scaled for current acc[c].
  - acc[c] <= en[c] ? acc[c] + step_q : 0.
  - step_q <= freq_step.
- The frequency step therefore takes effect one frame after it is latched.
- While en[c] is low, acc[c] is forced to 0 on every cycle. Re-enabling always starts at phase 0 plus phase_off.
- pulse[c] <= en[c] & (cnt < duty_act[c]). It is registered every cycle.
- wrap[c] <= frame_end & en[c] & carry-out of acc[c] + step_q.
- frame_tick <= frame_end.

## Timing
- Reset values: cnt=0, acc=0, step_q=0, duty_act=0, pulse=0, frame_tick=0, wrap=0. The first frame after reset outputs 0% duty on all channels.
- pulse lags cnt by one cycle. duty_act=D gives a high pulse from cycle 1 through cycle D of each frame, counting cycle 0 as the first cycle after frame_end.
- Duty bounds:
  - D=0 keeps the output constant low.
  - D=2^PWM_W−1 gives 2^PWM_W−1 high cycles per frame. 100% duty is never produced.
- Changes to freq_step, phase_off, or amp during a frame affect only the duty loaded at the next frame_end. duty_act never changes mid-frame.
- Deasserting en[c] mid-frame forces pulse[c] low on the next edge. Reasserting it mid-frame lets the current duty_act resume immediately.
- The accumulator wraps silently modulo 2^ACC_W. freq_step=0 freezes the phase.
- Asserting rst_n low at any point clears all state immediately. Operation restarts at cnt=0 on the first edge after release.
- Sine period = 2^ACC_W / freq_step frames × 2^PWM_W cycles.

## Test plan
- Defaults, en=2'b01, freq_step=64, amp=64, phase_off=0:
  - The channel 0 per-frame high count follows 0,0,0,1,1,3,4,6,…, with one leading zero frame from reset.
  - Count 63 appears in two consecutive frames.
  - wrap[0] fires every 64 frames, i.e. 4096 cycles.
  - Channel 1 stays low.
- phase_off for channel 1 = 2048 (half period), both enabled:
  - Channel 1 high counts equal channel 0's shifted by 32 frames.
  - When channel 0 duty is 0, channel 1 duty is 63.
- amp=32:
  - Each duty equals floor(ROM*32/64); peak 31, entry 15 gives 15.
  - amp=127 gives exactly the same results as amp=64.
- Change freq_step from 64 to 128 at mid-frame cycle 30:
  - The loaded duties keep the old step for one frame, then advance 2 LUT entries per frame.
  - Only frame boundaries are affected; no mid-frame duty change.
- Drop en[0] at cnt=10:
  - pulse[0]=0 from the next edge, and acc is cleared.
  - On re-enable, the sequence restarts from entry 0.
- Pulse rst_n low for 3 cycles mid-frame:
  - All outputs are 0 while reset is low.
  - cnt restarts at 0.
  - frame_tick first asserts 64 cycles after release.

Source files
------------

// File: rtl/sine_pwm_multi.sv
// Multi-channel PWM sine generator: shared frame counter, per-channel phase accumulator,
// half-wave mirrored duty lookup with amplitude scaling, duty swapped only at frame ends.

module sine_pwm_lane #(
    parameter int PWM_W  = 6,
    parameter int ACC_W  = 12,
    parameter int LUT_AW = 5
) (
    input  logic             sysclk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             frame_end,
    input  logic [PWM_W-1:0] cnt,
    input  logic [ACC_W-1:0] step_q,
    input  logic [ACC_W-1:0] phase_off,
    input  logic [PWM_W:0]   amp_eff,
    output logic             pulse,
    output logic             wrap
);
    // Built-in raised-cosine half wave (32 x 6 bit), resampled to LUT_AW / PWM_W.
    function automatic logic [PWM_W-1:0] rom(input logic [LUT_AW-1:0] idx);
        logic [4:0] i32;
        logic [5:0] v;
        i32 = 5'((32'(idx) << 5) >> LUT_AW);
        case (i32)
            5'd0:  v = 6'd0;   5'd1:  v = 6'd0;   5'd2:  v = 6'd1;   5'd3:  v = 6'd1;
            5'd4:  v = 6'd3;   5'd5:  v = 6'd4;   5'd6:  v = 6'd6;   5'd7:  v = 6'd8;
            5'd8:  v = 6'd10;  5'd9:  v = 6'd12;  5'd10: v = 6'd15;  5'd11: v = 6'd18;
            5'd12: v = 6'd21;  5'd13: v = 6'd24;  5'd14: v = 6'd27;  5'd15: v = 6'd30;
            5'd16: v = 6'd33;  5'd17: v = 6'd36;  5'd18: v = 6'd39;  5'd19: v = 6'd42;
            5'd20: v = 6'd45;  5'd21: v = 6'd48;  5'd22: v = 6'd51;  5'd23: v = 6'd53;
            5'd24: v = 6'd55;  5'd25: v = 6'd57;  5'd26: v = 6'd59;  5'd27: v = 6'd60;
            5'd28: v = 6'd62;  5'd29: v = 6'd62;  5'd30: v = 6'd63;  default: v = 6'd63;
        endcase
        return PWM_W'((32'(v) << PWM_W) >> 6);
    endfunction

    logic [ACC_W-1:0]  acc;
    logic [ACC_W:0]    acc_sum;
    logic [LUT_AW:0]   p_hi;
    logic [LUT_AW-1:0] addr;
    logic [PWM_W-1:0]  raw, scaled, duty_act;

    // Only the half-select bit and the LUT address of acc+phase_off matter.
    assign p_hi    = (LUT_AW+1)'((acc + phase_off) >> (ACC_W - 1 - LUT_AW));
    assign addr    = p_hi[LUT_AW] ? ~p_hi[LUT_AW-1:0] : p_hi[LUT_AW-1:0];
    assign raw     = rom(addr);
    assign scaled  = PWM_W'(((2*PWM_W+1)'(raw) * (2*PWM_W+1)'(amp_eff)) >> PWM_W);
    assign acc_sum = {1'b0, acc} + {1'b0, step_q};

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            duty_act <= '0;
            pulse    <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            pulse <= en & (cnt < duty_act);
            wrap  <= frame_end & en & acc_sum[ACC_W];
            if (frame_end)
                duty_act <= scaled;
            if (!en)
                acc <= '0;
            else if (frame_end)
                acc <= acc_sum[ACC_W-1:0];
        end
    end
endmodule

module sine_pwm_multi #(
    parameter int CHANNELS = 2,
    parameter int PWM_W    = 6,
    parameter int ACC_W    = 12,
    parameter int LUT_AW   = 5,
    parameter     LUT_FILE = "sine_half.hex"
) (
    input  logic                      sysclk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       en,
    input  logic [ACC_W-1:0]          freq_step,
    input  logic [CHANNELS*ACC_W-1:0] phase_off,
    input  logic [PWM_W:0]            amp,
    output logic [CHANNELS-1:0]       pulse,
    output logic                      frame_tick,
    output logic [CHANNELS-1:0]       wrap
);
    localparam logic [PWM_W:0] UNITY = (PWM_W+1)'(1) << PWM_W;

    // The sine image is compiled into the lanes; only the default image is available.
    if (LUT_FILE != "sine_half.hex" || ACC_W < LUT_AW + 1) begin : g_param_chk
        $error("sine_pwm_multi: unsupported LUT_FILE or ACC_W < LUT_AW+1");
    end

    logic [PWM_W-1:0] cnt;
    logic [ACC_W-1:0] step_q;
    logic [PWM_W:0]   amp_eff;
    logic             frame_end;

    assign frame_end = (cnt == '1);
    assign amp_eff   = (amp > UNITY) ? UNITY : amp;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            step_q     <= '0;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= cnt + PWM_W'(1);
            frame_tick <= frame_end;
            if (frame_end)
                step_q <= freq_step;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        sine_pwm_lane #(
            .PWM_W (PWM_W),
            .ACC_W (ACC_W),
            .LUT_AW(LUT_AW)
        ) u_lane (
            .sysclk   (sysclk),
            .rst_n    (rst_n),
            .en       (en[c]),
            .frame_end(frame_end),
            .cnt      (cnt),
            .step_q   (step_q),
            .phase_off(phase_off[c*ACC_W +: ACC_W]),
            .amp_eff  (amp_eff),
            .pulse    (pulse[c]),
            .wrap     (wrap[c])
        );
    end
endmodule

// File: tb/tb_sine_pwm_multi.sv
// Bench for sine_pwm_multi: cycle reference model built from phase/frame arithmetic,
// directed test-plan scenarios followed by randomized parameter changes.

module tb_sine_pwm_multi;
    logic        sysclk = 1'b0;
    logic        rst_n;
    logic [1:0]  en;
    logic [11:0] freq_step;
    logic [23:0] phase_off;
    logic [6:0]  amp;
    logic [1:0]  pulse;
    logic        frame_tick;
    logic [1:0]  wrap;

    sine_pwm_multi dut (
        .sysclk    (sysclk),
        .rst_n     (rst_n),
        .en        (en),
        .freq_step (freq_step),
        .phase_off (phase_off),
        .amp       (amp),
        .pulse     (pulse),
        .frame_tick(frame_tick),
        .wrap      (wrap)
    );

    always #5 sysclk = ~sysclk;

    int rom_t [32] = '{0,0,1,1,3,4,6,8,10,12,15,18,21,24,27,30,
                       33,36,39,42,45,48,51,53,55,57,59,60,62,62,63,63};

    int n_chk = 0;
    int n_err = 0;

    // reference state
    int         m_cnt, m_step;
    int         m_acc [2];
    int         m_duty[2];
    logic [1:0] m_pulse, m_wrap;
    logic       m_tick;

    // observed per-frame statistics
    int cyc;
    int hc0, hc1;
    int q0[$], q1[$], wq0[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // A full period is 4096 phase units = 64 steps of the mirrored 32-entry half wave.
    function automatic int ref_duty(input int acc, input int off, input int amp_v);
        int ph, idx, r;
        ph  = (acc + off) % 4096;
        idx = ph / 64;
        r   = (idx < 32) ? rom_t[idx] : rom_t[63 - idx];
        return r * ((amp_v > 64) ? 64 : amp_v) / 64;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_step = 0; m_pulse = '0; m_wrap = '0; m_tick = 1'b0;
        for (int c = 0; c < 2; c++) begin m_acc[c] = 0; m_duty[c] = 0; end
    endtask

    task automatic clear_stats();
        hc0 = 0; hc1 = 0;
        q0.delete(); q1.delete(); wq0.delete();
    endtask

    // One clock: predict from inputs held before the edge, then compare #1 after it.
    task automatic step();
        int         n_acc [2];
        int         n_duty[2];
        logic [1:0] n_pulse, n_wrap;
        bit         fe;
        fe = (m_cnt == 63);
        for (int c = 0; c < 2; c++) begin
            int off;
            off        = int'(phase_off[c*12 +: 12]);
            n_pulse[c] = en[c] && (m_cnt < m_duty[c]);
            n_wrap[c]  = fe && en[c] && (m_acc[c] + m_step >= 4096);
            n_duty[c]  = fe ? ref_duty(m_acc[c], off, int'(amp)) : m_duty[c];
            n_acc[c]   = !en[c] ? 0 : (fe ? (m_acc[c] + m_step) % 4096 : m_acc[c]);
        end
        @(posedge sysclk);
        if (!rst_n) model_reset();
        else begin
            m_pulse = n_pulse; m_wrap = n_wrap; m_tick = fe;
            if (fe) m_step = int'(freq_step);
            m_cnt = (m_cnt + 1) % 64;
            for (int c = 0; c < 2; c++) begin m_acc[c] = n_acc[c]; m_duty[c] = n_duty[c]; end
        end
        #1;
        cyc++;
        chk("outputs{tick,wrap,pulse}", 32'({frame_tick, wrap, pulse}), 32'({m_tick, m_wrap, m_pulse}));
        if (frame_tick) begin
            q0.push_back(hc0); q1.push_back(hc1); hc0 = 0; hc1 = 0;
        end
        hc0 += int'(pulse[0]);
        hc1 += int'(pulse[1]);
        if (wrap[0]) wq0.push_back(cyc);
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n * 64; i++) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("async_reset_clear", 32'({frame_tick, wrap, pulse}), 32'd0);
        model_reset();
        for (int i = 0; i < 3; i++) step();
        rst_n = 1'b1;
        clear_stats();
    endtask

    initial begin
        int first_nz, run, best, mism, bad, mx, n;
        cyc = 0;
        rst_n = 1'b0; en = 2'b00; freq_step = '0; phase_off = '0; amp = '0;
        model_reset();
        clear_stats();
        #12;
        chk("reset_pulse", 32'(pulse), 32'd0);
        chk("reset_wrap", 32'(wrap), 32'd0);
        chk("reset_tick", 32'(frame_tick), 32'd0);

        // Channel 0 alone, unity amplitude, step 64.
        rst_n = 1'b1; en = 2'b01; freq_step = 12'd64; amp = 7'd64;
        run_frames(140);
        first_nz = -1;
        for (int i = 0; i < q0.size(); i++) if (first_nz < 0 && q0[i] != 0) first_nz = i;
        if (first_nz < 1 || first_nz + 3 >= q0.size()) first_nz = 1;
        chk("ramp0", 32'(q0[first_nz]), 32'd1);
        chk("ramp1", 32'(q0[first_nz+1]), 32'd1);
        chk("ramp2", 32'(q0[first_nz+2]), 32'd3);
        chk("ramp3", 32'(q0[first_nz+3]), 32'd4);
        run = 0; best = 0;
        foreach (q0[i]) begin
            run  = (q0[i] == 63) ? run + 1 : 0;
            best = (run > best) ? run : best;
        end
        chk("peak_repeats", 32'(best >= 2), 32'd1);
        chk("wrap_period", (wq0.size() >= 2) ? 32'(wq0[1] - wq0[0]) : 32'hFFFF_FFFF, 32'd4096);
        n = 0;
        foreach (q1[i]) n += q1[i];
        chk("ch1_idle", 32'(n), 32'd0);

        // Half-period offset on channel 1.
        do_reset();
        en = 2'b11; phase_off = {12'd2048, 12'd0};
        run_frames(100);
        mism = 0; bad = 0;
        for (int i = 4; i < 60; i++) begin
            if (q1[i] != q0[i+32]) mism++;
            if (q0[i] == 0 && q1[i] != 63) bad++;
        end
        chk("half_shift", 32'(mism), 32'd0);
        chk("zero_vs_peak", 32'(bad), 32'd0);

        // Half amplitude, then over-range amplitude clamped to unity.
        amp = 7'd32;
        run_frames(66);
        mx = 0;
        for (int i = q0.size() - 64; i < q0.size(); i++) mx = (q0[i] > mx) ? q0[i] : mx;
        chk("amp32_peak", 32'(mx), 32'd31);
        amp = 7'd127;
        run_frames(66);
        mx = 0;
        for (int i = q0.size() - 64; i < q0.size(); i++) mx = (q0[i] > mx) ? q0[i] : mx;
        chk("amp127_peak", 32'(mx), 32'd63);

        // Frequency change mid-frame.
        while (m_cnt != 30) step();
        freq_step = 12'd128;
        run_frames(10);

        // Enable drop at cnt=10, later re-enable.
        while (m_cnt != 10) step();
        en = 2'b10;
        step();
        chk("en_drop_pulse0", 32'(pulse[0]), 32'd0);
        run_frames(2);
        en = 2'b11;
        run_frames(4);

        // Reset mid-frame, first frame_tick 64 cycles after release.
        while (m_cnt != 20) step();
        do_reset();
        n = 0;
        while (!frame_tick && n < 200) begin step(); n++; end
        chk("tick_after_release", 32'(n), 32'd64);

        // Randomized parameter changes at random points in the frame.
        for (int f = 0; f < 60; f++) begin
            int at;
            at = int'($urandom_range(0, 63));
            for (int i = 0; i < 64; i++) begin
                if (i == at) begin
                    freq_step = 12'($urandom_range(0, 4095));
                    phase_off = {12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095))};
                    amp       = 7'($urandom_range(0, 127));
                    if ($urandom_range(0, 3) == 0) en = 2'($urandom_range(0, 3));
                end
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
